// File: rtl/seg_scan_if.sv
// Handshake/pin bundle between the value source, the scan controller and the
// seven-segment pins. The master drives the value and enables; the slave drives the pins.
interface seg_scan_if;
  logic [31:0] value;
  logic        load;
  logic [7:0]  digit_en;
  logic [7:0]  dp_en;
  logic        lz_suppress;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output value, load, digit_en, dp_en, lz_suppress,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  value, load, digit_en, dp_en, lz_suppress,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Eight-digit multiplexed seven-segment scanner with a tear-free shadow value,
// per-slot blanking guard and leading-zero suppression. All pin outputs are active-low.
module seg_scan_controller #(
  parameter int DIGIT_CYC = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       n_rst,
  seg_scan_if.slave  bus
);
  localparam int CW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] CNT_BEND = CW'(BLANK_CYC - 1);

  typedef enum logic {BLANK, DRIVE} phase_e;

  phase_e      phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] staging_q, staging_d;
  logic        pending_q, pending_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        fd_q, fd_d;

  logic        slot_end, boundary, lit, suppressed;
  logic [7:0]  zero_from;
  logic [3:0]  nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h7E;
      4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;
      4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;
      4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;
      4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h7B;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;
      4'hD: glyph = 7'h3D;
      4'hE: glyph = 7'h4F;
      default: glyph = 7'h47;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      phase_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    boundary  = slot_end && (idx_q == 3'd7);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
    phase_d   = phase_q;
    staging_d = staging_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;

    if (slot_end)
      phase_d = BLANK;
    else if (cnt_q == CNT_BEND)
      phase_d = DRIVE;

    if (bus.load) begin
      staging_d = bus.value;
      pending_d = 1'b1;
    end
    // A load in the boundary cycle bypasses staging so it is not lost for a frame.
    if (boundary) begin
      if (bus.load) begin
        shadow_d  = bus.value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = staging_q;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    zero_from    = '0;
    zero_from[7] = (shadow_q[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--)
      zero_from[k] = zero_from[k+1] && (shadow_q[4*k +: 4] == 4'h0);

    nib        = shadow_q[{idx_q, 2'b00} +: 4];
    suppressed = bus.lz_suppress && (idx_q != 3'd0) && zero_from[idx_q];
    lit        = (phase_q == DRIVE) && bus.digit_en[idx_q] && !suppressed;

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fd_d  = boundary;
    if (lit) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = ~glyph(nib);
      dp_d  = ~bus.dp_en[idx_q];
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench: a time-since-reset model predicts every registered pin cycle;
// a monitor pops and compares after each clock edge.
module tb_seg_scan_controller;
  localparam int D = 8;
  localparam int B = 2;
  localparam int FRAME = 8 * D;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  seg_scan_if bus ();
  seg_scan_controller #(.DIGIT_CYC(D), .BLANK_CYC(B)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus.slave)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] GLY [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model state: cycles since reset release, displayed value, latest requested value.
  int          t = 0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_staging = '0;
  bit          m_pend = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Predict the pins after the coming edge, advance the model, then clock.
  task automatic step();
    exp_t e;
    int slot, pos;
    bit lit, sup;
    logic [7:0] one;
    one = 8'h01;
    if (!n_rst) begin
      e = '{8'hFF, 7'h7F, 1'b1, 1'b0};
      t = 0; m_shadow = '0; m_staging = '0; m_pend = 0;
    end else begin
      slot = (t / D) % 8;
      pos  = t % D;
      sup  = bus.lz_suppress && slot != 0 && ((m_shadow >> (4 * slot)) == 32'd0);
      lit  = pos >= B && bus.digit_en[slot] && !sup;
      e.an  = lit ? ~(one << slot) : 8'hFF;
      e.seg = lit ? ~GLY[m_shadow[4*slot +: 4]] : 7'h7F;
      e.dp  = lit ? ~bus.dp_en[slot] : 1'b1;
      e.fd  = (t % FRAME) == FRAME - 1;
      if (bus.load) begin
        m_staging = bus.value;
        m_pend = 1;
      end
      if ((t % FRAME) == FRAME - 1 && m_pend) begin
        m_shadow = m_staging;
        m_pend = 0;
      end
      t++;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model is at frame position p (bounded to one frame).
  task automatic goto_pos(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) step();
  endtask

  task automatic do_load(input logic [31:0] v);
    bus.value = v;
    bus.load = 1'b1;
    step();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("an", {24'd0, bus.an}, {24'd0, e.an});
        chk("seg", {25'd0, bus.seg}, {25'd0, e.seg});
        chk("dp", {31'd0, bus.dp}, {31'd0, e.dp});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    bus.value = '0;
    bus.load = 1'b0;
    bus.digit_en = 8'hFF;
    bus.dp_en = 8'h00;
    bus.lz_suppress = 1'b0;

    // Reset held three cycles, then idle frame showing zeros.
    run(3);
    n_rst = 1'b1;
    run(FRAME + 4);

    // Full frame of distinct glyphs.
    do_load(32'h89ABCDEF);
    goto_pos(0);
    run(2 * FRAME);

    // Tear-free load: two loads within one frame, latest wins.
    do_load(32'h22222222);
    goto_pos(0);
    run(3 * D + 1);
    do_load(32'h11111111);
    goto_pos(6 * D + 3);
    do_load(32'h33333333);
    goto_pos(0);
    run(FRAME + 5);

    // Load exactly at the frame boundary.
    goto_pos(FRAME - 1);
    do_load(32'h00000005);
    run(FRAME);

    // Leading-zero suppression with masks.
    bus.lz_suppress = 1'b1;
    bus.digit_en = 8'hFB;
    bus.dp_en = 8'h02;
    do_load(32'h00000A00);
    goto_pos(0);
    run(2 * FRAME);
    bus.lz_suppress = 1'b0;
    bus.digit_en = 8'hFF;
    bus.dp_en = 8'h00;

    // Reset in slot 4 with a load pending.
    goto_pos(1);
    do_load(32'h12345678);
    goto_pos(4 * D + 3);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    run(2 * FRAME);

    // Randomized traffic including live enable changes and rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) begin
        bus.value = $urandom;
        if ($urandom_range(1) == 0) bus.value = bus.value >> (4 * $urandom_range(7));
        bus.load = 1'b1;
      end
      if ($urandom_range(31) == 0) bus.digit_en = 8'($urandom);
      if ($urandom_range(31) == 0) bus.dp_en = 8'($urandom);
      if ($urandom_range(63) == 0) bus.lz_suppress = 1'($urandom);
      n_rst = ($urandom_range(299) != 0);
      step();
    end
    n_rst = 1'b1;
    run(3);

    @(posedge clk);
    #2;
    chk("drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
